// File: rtl/prio_interrupt_controller.sv
// Priority interrupt controller: the lowest-index pending source wins. Request to proc_interrupt takes 2 cycles, and there is no backpressure.
// Define INTC_EDGE_DETECT_EN to latch requests on rising edges; the default build latches on level.
module prio_interrupt_controller #(
  parameter int NUM_SRC       = 32,
  parameter int PULSE_LEN     = 7,
  parameter int RETRIG_CYCLES = 0,
  localparam int ID_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               irq_clear,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] service,
  output logic [ID_W-1:0]    service_id,
  output logic               proc_interrupt
);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

  localparam logic [7:0]  PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [15:0] WAIT_LAST  = 16'((RETRIG_CYCLES > 0) ? RETRIG_CYCLES - 1 : 0);

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] service_q, service_d;
  logic [ID_W-1:0]    service_id_q, service_id_d;
  logic [7:0]         pulse_cnt_q, pulse_cnt_d;
  logic [15:0]        wait_cnt_q, wait_cnt_d;
  logic [NUM_SRC-1:0] set_vec, clr_vec, pick_vec;
  logic [ID_W-1:0]    pick_id;
  logic               ack;

`ifdef INTC_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] irq_hist_q, irq_hist_d;

  always_comb begin
    irq_hist_d = irq_in;
    set_vec    = irq_in & ~irq_hist_q;
  end

  always_ff @(posedge clk) begin
    if (srst) irq_hist_q <= '0;
    else      irq_hist_q <= irq_hist_d;
  end
`else
  assign set_vec = irq_in;
`endif

  // An acknowledge only counts while a source is actually in service.
  assign ack = irq_clear && (state_q != IDLE);

  always_comb begin
    pick_vec = '0;
    pick_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pick_vec    = '0;
        pick_vec[i] = 1'b1;
        pick_id     = ID_W'(i);
      end
    end
  end

  always_comb begin
    clr_vec   = ack ? service_q : '0;
    pending_d = irq_mask & (pending_q | set_vec) & ~clr_vec;
  end

  always_comb begin
    state_d      = state_q;
    service_d    = service_q;
    service_id_d = service_id_q;
    pulse_cnt_d  = pulse_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d      = PULSE;
          service_d    = pick_vec;
          service_id_d = pick_id;
          pulse_cnt_d  = '0;
        end
      end
      PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d     = WAIT;
          pulse_cnt_d = '0;
          wait_cnt_d  = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (RETRIG_CYCLES != 0) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d     = PULSE;
            wait_cnt_d  = '0;
            pulse_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (ack) begin
      state_d      = IDLE;
      service_d    = '0;
      service_id_d = '0;
      pulse_cnt_d  = '0;
      wait_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      service_q    <= '0;
      service_id_q <= '0;
      pulse_cnt_q  <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      service_q    <= service_d;
      service_id_q <= service_id_d;
      pulse_cnt_q  <= pulse_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign pending        = pending_q;
  assign service        = service_q;
  assign service_id     = service_id_q;
  assign proc_interrupt = (state_q == PULSE);

endmodule

// File: tb/tb_prio_interrupt_controller.sv
// Bench for prio_interrupt_controller (32 sources, 7-cycle pulse, 20-cycle retrigger).
// Directed scenarios plus random traffic, checked against a source/age reference model.
module tb_prio_interrupt_controller;
  localparam int NS = 32;
  localparam int PL = 7;
  localparam int RT = 20;

  logic          clk;
  logic          srst;
  logic [NS-1:0] irq_in;
  logic [NS-1:0] irq_mask;
  logic          irq_clear;
  logic [NS-1:0] pending;
  logic [NS-1:0] service;
  logic [4:0]    service_id;
  logic          proc_interrupt;
  logic [69:0]   dut_vec;

  int errors = 0;
  int checks = 0;

  // Reference model: the pending set, the source in service (-1 when idle), and cycles since service began.
  logic [NS-1:0] m_pend;
  logic [NS-1:0] m_prev;
  int            m_svc;
  int            m_age;

  prio_interrupt_controller #(.NUM_SRC(NS), .PULSE_LEN(PL), .RETRIG_CYCLES(RT)) dut (
    .clk(clk), .srst(srst), .irq_in(irq_in), .irq_mask(irq_mask), .irq_clear(irq_clear),
    .pending(pending), .service(service), .service_id(service_id), .proc_interrupt(proc_interrupt)
  );

  assign dut_vec = {pending, service, service_id, proc_interrupt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [69:0] exp_vec();
    logic [NS-1:0] sv;
    logic [4:0]    id;
    logic          pr;
    int            svc;
    svc = m_svc;
    sv  = '0;
    id  = '0;
    pr  = 1'b0;
    if (svc >= 0) begin
      sv = 32'd1 << svc;
      id = svc[4:0];
      pr = (m_age % (PL + RT)) < PL;
    end
    return {m_pend, sv, id, pr};
  endfunction

  task automatic tick();
    logic [NS-1:0] set;
    logic [NS-1:0] np;
    int            nsvc;
    @(posedge clk);
    if (srst) begin
      m_pend = '0;
      m_prev = '0;
      m_svc  = -1;
      m_age  = 0;
    end else begin
`ifdef INTC_EDGE_DETECT_EN
      set = irq_in & ~m_prev;
`else
      set = irq_in;
`endif
      for (int i = 0; i < NS; i++)
        np[i] = irq_mask[i] && (m_pend[i] || set[i]) && !(irq_clear && m_svc == i);
      nsvc = m_svc;
      if (m_svc < 0) begin
        for (int i = 0; i < NS; i++)
          if (m_pend[i] && nsvc < 0) nsvc = i;
        m_age = 0;
      end else if (irq_clear) begin
        nsvc = -1;
      end else begin
        m_age = m_age + 1;
      end
      m_svc  = nsvc;
      m_pend = np;
      m_prev = irq_in;
    end
    #1;
  endtask

  task automatic do_reset();
    srst      = 1'b1;
    irq_in    = '0;
    irq_clear = 1'b0;
    irq_mask  = '1;
    tick();
    srst = 1'b0;
  endtask

  task automatic test_reset();
    srst      = 1'b1;
    irq_in    = 32'hFFFF_FFFF;
    irq_mask  = '1;
    irq_clear = 1'b1;
    tick();
    tick();
    checks++;
    if (dut_vec !== 70'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", dut_vec);
    end
    srst      = 1'b0;
    irq_in    = '0;
    irq_clear = 1'b0;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single();
    do_reset();
    irq_in = 32'h0000_0010;
    tick();
    checks++;
    if (pending !== 32'h10 || service !== 32'h0 || proc_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL single_latch: got pend=%h svc=%h pi=%b want pend=10 svc=0 pi=0", pending, service, proc_interrupt);
    end
    irq_in = '0;
    tick();
    checks++;
    if (service !== 32'h10 || service_id !== 5'd4 || proc_interrupt !== 1'b1) begin
      errors++;
      $display("FAIL single_service: got svc=%h id=%0d pi=%b want svc=10 id=4 pi=1", service, service_id, proc_interrupt);
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      checks++;
      if (proc_interrupt !== ((k % 27) < 7) || service !== 32'h10 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL retrig_k%0d: got pi=%b svc=%h vec=%h want pi=%b svc=10 vec=%h",
                 k, proc_interrupt, service, dut_vec, ((k % 27) < 7), exp_vec());
      end
    end
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    checks++;
    if (proc_interrupt !== 1'b0 || service !== 32'h0 || service_id !== 5'd0 || pending !== 32'h0) begin
      errors++;
      $display("FAIL clear_mid_pulse: got pi=%b svc=%h id=%0d pend=%h want all 0", proc_interrupt, service, service_id, pending);
    end
  endtask

  task automatic test_priority();
    do_reset();
    irq_in = 32'h0000_0A00;
    tick();
    irq_in = '0;
    tick();
    checks++;
    if (service_id !== 5'd9 || pending !== 32'hA00) begin
      errors++;
      $display("FAIL prio_first: got id=%0d pend=%h want id=9 pend=a00", service_id, pending);
    end
    repeat (3) tick();
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    checks++;
    if (service !== 32'h0 || pending !== 32'h800 || proc_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle_gap: got svc=%h pend=%h pi=%b want svc=0 pend=800 pi=0", service, pending, proc_interrupt);
    end
    tick();
    checks++;
    if (service_id !== 5'd11 || service !== 32'h800 || proc_interrupt !== 1'b1) begin
      errors++;
      $display("FAIL prio_second: got id=%0d svc=%h pi=%b want id=11 svc=800 pi=1", service_id, service, proc_interrupt);
    end
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
  endtask

  task automatic test_mask();
    logic lvl;
`ifdef INTC_EDGE_DETECT_EN
    lvl = 1'b0;
`else
    lvl = 1'b1;
`endif
    do_reset();
    irq_mask = ~32'h8;
    irq_in   = 32'h8;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (pending !== 32'h0 || proc_interrupt !== 1'b0) begin
        errors++;
        $display("FAIL masked_k%0d: got pend=%h pi=%b want pend=0 pi=0", k, pending, proc_interrupt);
      end
    end
    irq_mask = '1;
    tick();
    tick();
    checks++;
    if (service !== (lvl ? 32'h8 : 32'h0) || proc_interrupt !== lvl) begin
      errors++;
      $display("FAIL unmask_latency: got svc=%h pi=%b want svc=%h pi=%b", service, proc_interrupt, (lvl ? 32'h8 : 32'h0), lvl);
    end
    tick();
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    checks++;
    if (pending[3] !== 1'b0 || service !== 32'h0) begin
      errors++;
      $display("FAIL clear_held: got pend3=%b svc=%h want pend3=0 svc=0", pending[3], service);
    end
    tick();
    checks++;
    if (pending[3] !== lvl || service !== 32'h0) begin
      errors++;
      $display("FAIL relatch: got pend3=%b svc=%h want pend3=%b svc=0", pending[3], service, lvl);
    end
    tick();
    checks++;
    if (service !== (lvl ? 32'h8 : 32'h0) || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reservice: got svc=%h vec=%h want svc=%h vec=%h", service, dut_vec, (lvl ? 32'h8 : 32'h0), exp_vec());
    end
    irq_in    = '0;
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    irq_in    = 32'h8;
    tick();
    tick();
    checks++;
    if (service !== 32'h8 || service_id !== 5'd3 || proc_interrupt !== 1'b1) begin
      errors++;
      $display("FAIL new_edge: got svc=%h id=%0d pi=%b want svc=8 id=3 pi=1", service, service_id, proc_interrupt);
    end
    irq_in    = '0;
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
  endtask

  task automatic test_clear_vs_set();
    logic lvl;
`ifdef INTC_EDGE_DETECT_EN
    lvl = 1'b0;
`else
    lvl = 1'b1;
`endif
    do_reset();
    irq_in = 32'h20;
    tick();
    irq_in = '0;
    repeat (3) tick();
    irq_in    = 32'h20;
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    checks++;
    if (pending[5] !== 1'b0 || service !== 32'h0) begin
      errors++;
      $display("FAIL clear_wins: got pend5=%b svc=%h want pend5=0 svc=0", pending[5], service);
    end
    tick();
    checks++;
    if (pending[5] !== lvl) begin
      errors++;
      $display("FAIL clear_then_relatch: got pend5=%b want %b", pending[5], lvl);
    end
    irq_in = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    irq_in = 32'h6;
    tick();
    irq_in = '0;
    tick();
    checks++;
    if (service !== 32'h2 || service_id !== 5'd1 || pending !== 32'h6 || proc_interrupt !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got svc=%h id=%0d pend=%h pi=%b want svc=2 id=1 pend=6 pi=1",
               service, service_id, pending, proc_interrupt);
    end
    tick();
    srst      = 1'b1;
    irq_in    = 32'hFF;
    irq_clear = 1'b1;
    tick();
    checks++;
    if (dut_vec !== 70'd0) begin
      errors++;
      $display("FAIL reset_mid_pulse: got %h want 0", dut_vec);
    end
    srst      = 1'b0;
    irq_in    = '0;
    irq_clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (proc_interrupt !== 1'b0 || pending !== 32'h0 || service !== 32'h0) begin
        errors++;
        $display("FAIL post_reset_k%0d: got pi=%b pend=%h svc=%h want all 0", k, proc_interrupt, pending, service);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      irq_in    = $urandom & $urandom & $urandom;
      irq_mask  = ($urandom_range(0, 7) == 0) ? $urandom : 32'hFFFF_FFFF;
      irq_clear = ($urandom_range(0, 9) == 0);
      srst      = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_c%0d: got %h want %h", k, dut_vec, exp_vec());
      end
    end
    srst      = 1'b0;
    irq_clear = 1'b0;
    irq_in    = '0;
  endtask

  initial begin
    m_pend    = '0;
    m_prev    = '0;
    m_svc     = -1;
    m_age     = 0;
    srst      = 1'b1;
    irq_in    = '0;
    irq_mask  = '1;
    irq_clear = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_clear_vs_set();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
